// File: rtl/data_memory_pkg.sv
// Shared definitions for the off-chip data memory and the dcache index logic.
// Block geometry, FSM states and the address-to-block-index helper live here.
package data_memory_pkg;

    localparam int BLOCK_W     = 256;
    localparam int DEPTH       = 512;
    localparam int IDX_W       = $clog2(DEPTH);
    localparam int OFFSET_W    = $clog2(BLOCK_W / 8);
    localparam int DEF_LATENCY = 10;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    // Byte offset inside a block and the bits above 16 KB both drop out, so high addresses alias.
    function automatic idx_t block_index(input logic [31:0] addr);
        return idx_t'(addr >> OFFSET_W);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Main data memory: 512 x 256-bit blocks, whole-block read/write with a fixed
// req/ack latency. Contents survive reset; only the handshake FSM is cleared.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        addr_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               enable_i,
    input  logic               write_i,
    output logic               ack_o,
    output logic [BLOCK_W-1:0] data_o
);

    localparam int CNT_W = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

    block_t memory [0:DEPTH-1];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    idx_t             r_idx;
    block_t           r_wdata;
    logic             r_write;
    block_t           r_data_o;

    logic w_accept;
    logic w_last;
    logic w_commit;

    assign w_accept = (r_state == IDLE) && enable_i;
    assign w_last   = (r_state == BUSY) && (r_cnt == CNT_LAST);
    assign w_commit = w_last && r_write;

    // NOTE: every path assigns w_state_nxt after its default, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (enable_i) w_state_nxt = BUSY;
            BUSY:    if (w_last)   w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_idx   <= block_index(addr_i);
            r_wdata <= data_i;
            r_write <= write_i;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; contents must persist across rst_i.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            memory[r_idx] <= r_wdata;
        end
    end

    // A write returns the block it is committing, bypassing the array on the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data_o <= '0;
        end else if (w_last) begin
            r_data_o <= r_write ? r_wdata : memory[r_idx];
        end else begin
            r_data_o <= '0;
        end
    end

    assign ack_o  = (r_state == ACK);
    assign data_o = r_data_o;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: scoreboard of expected read blocks, latency and
// pulse-width checks, offset/alias decoding, back-to-back and mid-write reset.
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int LAT    = 10;
    localparam int BUDGET = 4 * LAT;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;

    int checks = 0;
    int errors = 0;

    logic [255:0] sb [$];

    data_memory #(.LATENCY(LAT)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until ack_o is seen (bounded), then pops and compares the scoreboard.
    task automatic wait_ack(input string tag, output int cycles);
        logic [255:0] exp;
        cycles = 0;
        while (cycles < BUDGET) begin
            @(negedge clk_i);
            cycles++;
            if (ack_o === 1'b1) break;
        end
        if (ack_o === 1'b1) begin
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check({tag, "_data"}, data_o, exp);
            end else begin
                check({tag, "_sb_empty"}, 256'(sb.size()), 256'(1));
            end
        end else begin
            check({tag, "_ack_timeout"}, 256'(ack_o), 256'(1));
        end
    endtask

    task automatic request(input string tag, input logic [31:0] a, input logic [255:0] d,
                           input logic w, input logic [255:0] exp);
        int cycles;
        @(negedge clk_i);
        addr_i   = a;
        data_i   = d;
        write_i  = w;
        enable_i = 1'b1;
        sb.push_back(exp);
        wait_ack(tag, cycles);
        check({tag, "_latency"}, 256'(cycles), 256'(LAT));
        enable_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_ack_width"}, 256'(ack_o), 256'(0));
        check({tag, "_data_idle"}, data_o, 256'(0));
    endtask

    initial begin
        logic [255:0] pat_beef;
        logic [255:0] blk1;
        logic [255:0] pat_a;
        logic [255:0] pat_b;
        logic [255:0] blk3;
        logic [255:0] blk4;
        logic [255:0] pat_e;
        int cycles;
        int acks;

        pat_beef = {8{32'hDEADBEEF}};
        blk1     = {4{64'h0123_4567_89AB_CDEF}};
        pat_a    = {16{16'hA5A5}};
        pat_b    = {16{16'h5A5A}};
        blk3     = {8{32'h3333_CCCC}};
        blk4     = {8{32'h4444_0F0F}};
        pat_e    = {8{32'hEEEE_1111}};

        rst_i    = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        enable_i = 1'b0;
        write_i  = 1'b0;

        repeat (3) @(negedge clk_i);
        check("reset_ack", 256'(ack_o), 256'(0));
        check("reset_data", data_o, 256'(0));

        dut.memory[0]  = 256'h5;
        dut.memory[1]  = blk1;
        dut.memory[3]  = blk3;
        dut.memory[4]  = blk4;
        dut.memory[32] = '0;
        rst_i = 1'b1;
        @(negedge clk_i);

        // Basic read with latency and pulse width.
        request("read0", 32'h0, '0, 1'b0, 256'h5);

        // Write returns the written block and lands in block 32.
        request("write400", 32'h400, pat_beef, 1'b1, pat_beef);
        check("mem32_after_write", dut.memory[32], pat_beef);
        request("read400", 32'h400, '0, 1'b0, pat_beef);

        // Offset bits ignored; addresses above 16 KB alias.
        request("read41f", 32'h41F, '0, 1'b0, pat_beef);
        request("read4020", 32'h4020, '0, 1'b0, blk1);

        // Back-to-back: request held high through the ack.
        @(negedge clk_i);
        addr_i   = 32'h0;
        write_i  = 1'b0;
        enable_i = 1'b1;
        sb.push_back(256'h5);
        sb.push_back(256'h5);
        wait_ack("b2b_first", cycles);
        check("b2b_first_latency", 256'(cycles), 256'(LAT));
        wait_ack("b2b_second", cycles);
        check("b2b_spacing", 256'(cycles), 256'(LAT + 1));
        enable_i = 1'b0;
        @(negedge clk_i);
        check("b2b_ack_width", 256'(ack_o), 256'(0));

        // Request fields changed during BUSY are ignored.
        @(negedge clk_i);
        addr_i   = 32'h40;
        data_i   = pat_a;
        write_i  = 1'b1;
        enable_i = 1'b1;
        sb.push_back(pat_a);
        repeat (3) @(negedge clk_i);
        addr_i  = 32'h60;
        data_i  = pat_b;
        write_i = 1'b0;
        wait_ack("busy_change", cycles);
        check("busy_change_latency", 256'(cycles + 3), 256'(LAT));
        enable_i = 1'b0;
        @(negedge clk_i);
        check("busy_change_mem2", dut.memory[2], pat_a);
        check("busy_change_mem3", dut.memory[3], blk3);

        // Reset in the middle of a write aborts it before the commit edge.
        @(negedge clk_i);
        addr_i   = 32'h80;
        data_i   = pat_e;
        write_i  = 1'b1;
        enable_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("midrst_busy_ack", 256'(ack_o), 256'(0));
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst_ack", 256'(ack_o), 256'(0));
        check("midrst_data", data_o, 256'(0));
        enable_i = 1'b0;
        repeat (LAT) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_state", 256'(dut.r_state), 256'(IDLE));
        acks = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) acks++;
        end
        check("midrst_no_ack", 256'(acks), 256'(0));
        check("midrst_mem4", dut.memory[4], blk4);
        request("midrst_read80", 32'h80, '0, 1'b0, blk4);

        check("sb_drained", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
